useq_ctrl: RTL and testbench
============================

# useq_ctrl

Micro-sequencer for the microprogrammed 8-bit CPU. It generates the next microinstruction address (upc) for the 24-bit control ROM from branch-control fields of the current microword, IR opcode and ALU status flags. It stalls the datapath while a RAM access is pending, and halts on fault. It replaces the free-running microaddress counter and drives the global execute enable that gates every register write strobe.

## Interface
Parameters:
- WAIT_MAX, 15: maximum consecutive RAM wait cycles before timeout (1..255).
- DISP_BASE, 8'h80: base microaddress of the opcode dispatch table.
- STK_DEPTH, 4: return-stack entries (1..7). Only meaningful with USEQ_STACK_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- run  in  1  1 = execute; 0 = freeze all state, exec_en=0.
- uinst_valid  in  1  current ROM word is valid.
- br_ctl  in  3  branch control field of the current microword.
- br_addr  in  8  branch target of the current microword.
- cond_sel  in  2  flag select: 00 carry, 01 borrow, 10 zero, 11 constant 0.
- cond_inv  in  1  invert the selected condition.
- flags  in  3  status register bits {zero, borrow, carry}.
- ir_op  in  4  opcode from IR.
- mem_req  in  1  current microword performs a RAM read or write.
- mem_ack  in  1  RAM access complete this cycle.
- upc  out  8  ROM address, registered.
- exec_en  out  1  microword may commit this cycle; combinational.
- halted  out  1  sequencer stopped; sticky until reset.
- stk_err  out  1  stack overflow or underflow; sticky.
- tmo  out  1  RAM wait timeout; sticky.
- depth  out  3  current return-stack occupancy.

## Operation
- exec_en = run & uinst_valid & ~halted & ~(mem_req & ~mem_ack).
- upc changes only on an edge where exec_en=1. Otherwise upc holds.
- br_ctl decode when exec_en=1:
  - 000 NEXT: upc+1. 8'hFF wraps to 8'h00.
  - 001 JMP: br_addr.
  - 010 DISPATCH: DISP_BASE + {ir_op,3'b000}, modulo 256.
  - 011 JCC: c = flags[cond_sel] ^ cond_inv, with cond_sel=11 giving c = cond_inv. If c=1, br_addr; else upc+1.
  - 100 CALL: push upc+1, upc <= br_addr.
  - 101 RET: pop into upc.
  - 110 FETCH: upc <= 8'h00.
  - 111 HALT: upc holds, halted <= 1.
- Stack is a LIFO of STK_DEPTH 8-bit entries.
  - CALL with depth==STK_DEPTH: no push, upc holds, stk_err <= 1, halted <= 1.
  - RET with depth==0: upc holds, stk_err <= 1, halted <= 1.
- Wait counter:
  - Increments on each edge with run & uinst_valid & ~halted & mem_req & ~mem_ack.
  - Clears on any edge with exec_en=1 or run=0.
  - On the edge ending the WAIT_MAX-th consecutive wait cycle: tmo <= 1, halted <= 1.
- Once halted, only rst clears state. HALT, stk_err and tmo all leave upc at the faulting microword.

## Timing
- Reset (rst=0 at an edge, overrides run and everything else): upc=0, halted=0, stk_err=0, tmo=0, depth=0, wait counter=0, stack contents don't-care.
- Reset asserted mid-stall or mid-CALL discards the pending operation.
- Next-address latency is one cycle: a microword executing in cycle n yields its new upc after the edge ending cycle n.
- flags and ir_op are sampled at that same edge. The datapath must present updated flags in the cycle of the JCC word itself.
- Priority: rst > halted > run=0 > uinst_valid=0 > RAM stall > br_ctl decode.
- mem_ack asserted in the same cycle as mem_req means no stall (exec_en=1).
- mem_ack with mem_req=0 is ignored.
- exec_en is combinational from inputs and halted only. It has no path from upc.

## Configuration
- USEQ_STACK_EN defined:
  - Return stack, CALL/RET and depth are implemented as in Operation.
- USEQ_STACK_EN undefined:
  - No stack storage.
  - CALL behaves as JMP; RET behaves as FETCH.
  - depth and stk_err are tied to 0.

## Test plan
- Reset then NEXT ×3 with run=1, uinst_valid=1 -> upc 0,1,2,3. Then rst=0 for one edge -> upc=0 and all flags 0.
- JCC with br_addr=8'h40, cond_sel=10, cond_inv=0: flags zero=1 -> upc=8'h40; zero=0 -> upc+1. DISPATCH with ir_op=4'h3 -> upc=8'h98.
- mem_req=1, mem_ack=0 for 3 cycles then 1 -> exec_en low 3 cycles, upc held, advances on 4th edge, tmo=0. With mem_ack held 0 for 15 cycles -> tmo=1, halted=1 at 15th edge.
- (USEQ_STACK_EN) CALL 8'h20 at upc=8'h05 -> upc=8'h20, depth=1. RET -> upc=8'h06, depth=0. Five nested CALLs -> fifth sets stk_err=1, halted=1, depth=4.
- run=0 during a DISPATCH word -> upc frozen, exec_en=0, wait counter cleared. HALT microword -> halted=1, upc unchanged, stays until rst.

Source files
------------

// File: rtl/useq_ctrl.sv
// useq_ctrl: next-microaddress sequencer for the microprogrammed 8-bit CPU.
// It generates upc from the microword branch field, stalls on pending RAM
// accesses, and halts on HALT, stack fault or RAM wait timeout.
// Build option: define USEQ_STACK_EN to add the CALL/RET return stack.
// Without it, CALL acts as JMP, RET acts as FETCH, and depth/stk_err read 0.
module useq_ctrl #(
  parameter int         WAIT_MAX  = 15,
  parameter logic [7:0] DISP_BASE = 8'h80,
  parameter int         STK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       uinst_valid,
  input  logic [2:0] br_ctl,
  input  logic [7:0] br_addr,
  input  logic [1:0] cond_sel,
  input  logic       cond_inv,
  input  logic [2:0] flags,
  input  logic [3:0] ir_op,
  input  logic       mem_req,
  input  logic       mem_ack,
  output logic [7:0] upc,
  output logic       exec_en,
  output logic       halted,
  output logic       stk_err,
  output logic       tmo,
  output logic [2:0] depth
);

  typedef enum logic [2:0] {
    BR_NEXT = 3'b000, BR_JMP = 3'b001, BR_DISP = 3'b010, BR_JCC  = 3'b011,
    BR_CALL = 3'b100, BR_RET = 3'b101, BR_FETCH = 3'b110, BR_HALT = 3'b111
  } br_t;

  // Wait count at the start of the last allowed stall cycle.
  localparam logic [7:0] LP_WLAST = 8'(WAIT_MAX - 1);

  // Reject out-of-range configurations at elaboration.
  if (WAIT_MAX < 1 || WAIT_MAX > 255 || STK_DEPTH < 1 || STK_DEPTH > 7) begin : g_bad_param
    $error("useq_ctrl: WAIT_MAX or STK_DEPTH out of range");
  end

  logic [7:0] r_upc;
  logic       r_halted;
  logic       r_tmo;
  logic [7:0] r_wcnt;
  logic [7:0] w_upc_inc;
  logic       w_cond;
  logic       w_live;
  logic       w_stall;
  logic       w_exec;

`ifdef USEQ_STACK_EN
  localparam int         AW      = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
  localparam logic [2:0] LP_DMAX = 3'(STK_DEPTH);
  logic [7:0]    r_stk [STK_DEPTH];
  logic [2:0]    r_depth;
  logic          r_stk_err;
  logic [AW-1:0] w_push_idx;
  logic [AW-1:0] w_pop_idx;
  // Top-of-stack slot is depth-1; the next free slot is depth.
  assign w_push_idx = r_depth[AW-1:0];
  assign w_pop_idx  = r_depth[AW-1:0] - AW'(1);
  assign depth      = r_depth;
  assign stk_err    = r_stk_err;
`else
  assign depth      = 3'd0;
  assign stk_err    = 1'b0;
`endif

  // exec_en never looks at upc: only the control inputs and the halt flag gate it.
  assign w_live    = run & uinst_valid & ~r_halted;
  assign w_stall   = w_live & mem_req & ~mem_ack;
  assign w_exec    = w_live & ~(mem_req & ~mem_ack);
  assign w_upc_inc = r_upc + 8'd1;

  assign upc     = r_upc;
  assign exec_en = w_exec;
  assign halted  = r_halted;
  assign tmo     = r_tmo;

  // Branch condition: selected status flag, optionally inverted; select 11 is constant 0.
  always_comb begin
    w_cond = cond_inv;
    case (cond_sel)
      2'b00:   w_cond = flags[0] ^ cond_inv;
      2'b01:   w_cond = flags[1] ^ cond_inv;
      2'b10:   w_cond = flags[2] ^ cond_inv;
      default: w_cond = cond_inv;
    endcase
  end

  // Sequencer state: next address, stall timeout, return stack and sticky faults.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_upc    <= 8'h00;
      r_halted <= 1'b0;
      r_tmo    <= 1'b0;
      r_wcnt   <= 8'h00;
`ifdef USEQ_STACK_EN
      r_depth   <= 3'd0;
      r_stk_err <= 1'b0;
`endif
    end else if (!r_halted) begin
      // Only back-to-back stall cycles count toward the timeout.
      if (!run || w_exec) begin
        r_wcnt <= 8'h00;
      end else if (w_stall) begin
        r_wcnt <= r_wcnt + 8'd1;
        if (r_wcnt == LP_WLAST) begin
          r_tmo    <= 1'b1;
          r_halted <= 1'b1;
        end
      end
      if (w_exec) begin
        case (br_t'(br_ctl))
          BR_NEXT:  r_upc <= w_upc_inc;
          BR_JMP:   r_upc <= br_addr;
          BR_DISP:  r_upc <= DISP_BASE + {1'b0, ir_op, 3'b000};
          BR_JCC:   r_upc <= w_cond ? br_addr : w_upc_inc;
`ifdef USEQ_STACK_EN
          BR_CALL: begin
            if (r_depth == LP_DMAX) begin
              r_stk_err <= 1'b1;
              r_halted  <= 1'b1;
            end else begin
              r_stk[w_push_idx] <= w_upc_inc;
              r_depth           <= r_depth + 3'd1;
              r_upc             <= br_addr;
            end
          end
          BR_RET: begin
            if (r_depth == 3'd0) begin
              r_stk_err <= 1'b1;
              r_halted  <= 1'b1;
            end else begin
              r_upc   <= r_stk[w_pop_idx];
              r_depth <= r_depth - 3'd1;
            end
          end
`else
          BR_CALL:  r_upc <= br_addr;
          BR_RET:   r_upc <= 8'h00;
`endif
          BR_FETCH: r_upc <= 8'h00;
          BR_HALT:  r_halted <= 1'b1;
          default:  r_upc <= r_upc;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_useq_ctrl.sv
// Self-checking bench for useq_ctrl: table of directed vectors plus
// hand-written sequences for stall timeout, reset mid-stall and the stack.
module tb_useq_ctrl;

  logic       clk = 1'b0;
  logic       rst, run, uinst_valid, cond_inv, mem_req, mem_ack;
  logic [2:0] br_ctl, flags;
  logic [7:0] br_addr;
  logic [1:0] cond_sel;
  logic [3:0] ir_op;
  logic [7:0] upc;
  logic       exec_en, halted, stk_err, tmo;
  logic [2:0] depth;

  int checks = 0;
  int errors = 0;

`ifdef USEQ_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  localparam logic [2:0] NX = 3'b000, JP = 3'b001, DS = 3'b010, JC = 3'b011,
                         CL = 3'b100, RT = 3'b101, FT = 3'b110, HL = 3'b111;

  useq_ctrl #(.WAIT_MAX(15), .DISP_BASE(8'h80), .STK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .run(run), .uinst_valid(uinst_valid),
    .br_ctl(br_ctl), .br_addr(br_addr), .cond_sel(cond_sel), .cond_inv(cond_inv),
    .flags(flags), .ir_op(ir_op), .mem_req(mem_req), .mem_ack(mem_ack),
    .upc(upc), .exec_en(exec_en), .halted(halted), .stk_err(stk_err),
    .tmo(tmo), .depth(depth)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, run, uv;
    logic [2:0] br;
    logic [7:0] addr;
    logic [1:0] cs;
    logic       ci;
    logic [2:0] fl;
    logic [3:0] op;
    logic       mrq, mak;
    logic       en;    // exec_en before the edge
    logic [7:0] upc;   // upc after the edge
    logic       hlt;
    logic [2:0] dep;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic rn, logic uv, logic [2:0] br, logic [7:0] a,
                              logic [1:0] cs, logic ci, logic [2:0] fl, logic [3:0] op,
                              logic mq, logic mk_, logic en, logic [7:0] u, logic h,
                              logic [2:0] d);
    vec_t v;
    v.rst = r; v.run = rn; v.uv = uv; v.br = br; v.addr = a; v.cs = cs; v.ci = ci;
    v.fl = fl; v.op = op; v.mrq = mq; v.mak = mk_; v.en = en; v.upc = u; v.hlt = h; v.dep = d;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drv(input vec_t v);
    rst = v.rst; run = v.run; uinst_valid = v.uv; br_ctl = v.br; br_addr = v.addr;
    cond_sel = v.cs; cond_inv = v.ci; flags = v.fl; ir_op = v.op;
    mem_req = v.mrq; mem_ack = v.mak;
  endtask

  // Short form for hand-written sequences: valid word, flags/opcode zero.
  task automatic go(input logic r, input logic rn, input logic [2:0] br,
                    input logic [7:0] a, input logic mq, input logic mk_);
    drv(mk(r, rn, 1'b1, br, a, 2'b00, 1'b0, 3'b000, 4'h0, mq, mk_,
           1'b0, 8'h00, 1'b0, 3'd0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ret_upc;
    ret_upc = STK ? 8'h06 : 8'h00;

    // rst, run, uv, br, addr, cs, ci, flags, op, mreq, mack | en, upc, halted, depth
    tbl.push_back(mk(1,1,1, NX, 8'h00, 0,0, 3'b000, 4'h0, 0,0, 1, 8'h01, 0, 0));
    tbl.push_back(mk(1,1,1, NX, 8'h00, 0,0, 3'b000, 4'h0, 0,0, 1, 8'h02, 0, 0));
    tbl.push_back(mk(1,1,1, NX, 8'h00, 0,0, 3'b000, 4'h0, 0,0, 1, 8'h03, 0, 0));
    tbl.push_back(mk(0,1,1, NX, 8'h00, 0,0, 3'b000, 4'h0, 0,0, 1, 8'h00, 0, 0));
    tbl.push_back(mk(1,1,1, JC, 8'h40, 2,0, 3'b100, 4'h0, 0,0, 1, 8'h40, 0, 0));
    tbl.push_back(mk(1,1,1, JC, 8'h40, 2,0, 3'b000, 4'h0, 0,0, 1, 8'h41, 0, 0));
    tbl.push_back(mk(1,1,1, JC, 8'h77, 0,1, 3'b001, 4'h0, 0,0, 1, 8'h42, 0, 0));
    tbl.push_back(mk(1,1,1, JC, 8'h10, 3,1, 3'b000, 4'h0, 0,0, 1, 8'h10, 0, 0));
    tbl.push_back(mk(1,1,1, JC, 8'h20, 3,0, 3'b111, 4'h0, 0,0, 1, 8'h11, 0, 0));
    tbl.push_back(mk(1,1,1, JC, 8'h30, 1,0, 3'b010, 4'h0, 0,0, 1, 8'h30, 0, 0));
    tbl.push_back(mk(1,1,1, JC, 8'h50, 1,1, 3'b010, 4'h0, 0,0, 1, 8'h31, 0, 0));
    tbl.push_back(mk(1,1,1, DS, 8'h00, 0,0, 3'b000, 4'h3, 0,0, 1, 8'h98, 0, 0));
    tbl.push_back(mk(1,1,1, DS, 8'h00, 0,0, 3'b000, 4'hF, 0,0, 1, 8'hF8, 0, 0));
    tbl.push_back(mk(1,1,1, JP, 8'hFF, 0,0, 3'b000, 4'h0, 0,0, 1, 8'hFF, 0, 0));
    tbl.push_back(mk(1,1,1, NX, 8'h00, 0,0, 3'b000, 4'h0, 0,0, 1, 8'h00, 0, 0));
    tbl.push_back(mk(1,1,0, JP, 8'h55, 0,0, 3'b000, 4'h0, 0,0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1,0,1, DS, 8'h00, 0,0, 3'b000, 4'h3, 0,0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1,1,1, JP, 8'h55, 0,0, 3'b000, 4'h0, 1,1, 1, 8'h55, 0, 0));
    tbl.push_back(mk(1,1,1, NX, 8'h00, 0,0, 3'b000, 4'h0, 0,1, 1, 8'h56, 0, 0));
    tbl.push_back(mk(1,1,1, NX, 8'h00, 0,0, 3'b000, 4'h0, 1,0, 0, 8'h56, 0, 0));
    tbl.push_back(mk(1,1,1, NX, 8'h00, 0,0, 3'b000, 4'h0, 1,0, 0, 8'h56, 0, 0));
    tbl.push_back(mk(1,1,1, NX, 8'h00, 0,0, 3'b000, 4'h0, 1,0, 0, 8'h56, 0, 0));
    tbl.push_back(mk(1,1,1, NX, 8'h00, 0,0, 3'b000, 4'h0, 1,1, 1, 8'h57, 0, 0));
    tbl.push_back(mk(1,1,1, FT, 8'h33, 0,0, 3'b000, 4'h0, 0,0, 1, 8'h00, 0, 0));
    tbl.push_back(mk(1,1,1, JP, 8'h05, 0,0, 3'b000, 4'h0, 0,0, 1, 8'h05, 0, 0));
    tbl.push_back(mk(1,1,1, CL, 8'h20, 0,0, 3'b000, 4'h0, 0,0, 1, 8'h20, 0, 3'(STK)));
    tbl.push_back(mk(1,1,1, RT, 8'h44, 0,0, 3'b000, 4'h0, 0,0, 1, ret_upc, 0, 0));
    tbl.push_back(mk(1,1,1, HL, 8'h44, 0,0, 3'b000, 4'h0, 0,0, 1, ret_upc, 1, 0));
    tbl.push_back(mk(1,1,1, NX, 8'h00, 0,0, 3'b000, 4'h0, 0,0, 0, ret_upc, 1, 0));
    tbl.push_back(mk(1,1,1, JP, 8'h66, 0,0, 3'b000, 4'h0, 0,0, 0, ret_upc, 1, 0));
    tbl.push_back(mk(0,0,1, NX, 8'h00, 0,0, 3'b000, 4'h0, 0,0, 0, 8'h00, 0, 0));

    // Power-on reset with run low.
    go(0, 0, NX, 8'h00, 0, 0);
    tick();
    chk("rst_upc", upc, 8'h00);
    chk("rst_halted", {7'd0, halted}, 8'd0);
    chk("rst_tmo", {7'd0, tmo}, 8'd0);
    chk("rst_stk_err", {7'd0, stk_err}, 8'd0);
    chk("rst_depth", {5'd0, depth}, 8'd0);
    chk("rst_exec_en", {7'd0, exec_en}, 8'd0);

    foreach (tbl[i]) begin
      drv(tbl[i]);
      #1;
      chk($sformatf("v%0d_exec_en", i), {7'd0, exec_en}, {7'd0, tbl[i].en});
      tick();
      chk($sformatf("v%0d_upc", i), upc, tbl[i].upc);
      chk($sformatf("v%0d_halted", i), {7'd0, halted}, {7'd0, tbl[i].hlt});
      chk($sformatf("v%0d_depth", i), {5'd0, depth}, {5'd0, tbl[i].dep});
      chk($sformatf("v%0d_stk_err", i), {7'd0, stk_err}, 8'd0);
      chk($sformatf("v%0d_tmo", i), {7'd0, tmo}, 8'd0);
    end

    // Timeout: a run=0 cycle restarts the count, then 15 straight stalls halt.
    for (int k = 0; k < 10; k++) begin go(1, 1, NX, 8'h00, 1, 0); tick(); end
    go(1, 0, NX, 8'h00, 1, 0); tick();
    for (int k = 0; k < 14; k++) begin go(1, 1, NX, 8'h00, 1, 0); tick(); end
    chk("to14_tmo", {7'd0, tmo}, 8'd0);
    chk("to14_halted", {7'd0, halted}, 8'd0);
    chk("to14_upc", upc, 8'h00);
    tick();
    chk("to15_tmo", {7'd0, tmo}, 8'd1);
    chk("to15_halted", {7'd0, halted}, 8'd1);
    chk("to15_upc", upc, 8'h00);
    go(1, 1, JP, 8'h77, 0, 1);
    #1;
    chk("to_halt_exec_en", {7'd0, exec_en}, 8'd0);
    tick();
    chk("to_halt_upc", upc, 8'h00);
    chk("to_sticky", {7'd0, tmo}, 8'd1);
    go(0, 1, NX, 8'h00, 0, 0); tick();
    chk("to_rst_tmo", {7'd0, tmo}, 8'd0);
    chk("to_rst_halted", {7'd0, halted}, 8'd0);

    // Reset in the middle of a stall drops the pending word and the wait count.
    go(1, 1, NX, 8'h00, 0, 0); tick();
    go(1, 1, NX, 8'h00, 0, 0); tick();
    chk("rs_pre_upc", upc, 8'h02);
    for (int k = 0; k < 10; k++) begin go(1, 1, NX, 8'h00, 1, 0); tick(); end
    go(0, 1, NX, 8'h00, 1, 0); tick();
    chk("rs_upc", upc, 8'h00);
    for (int k = 0; k < 14; k++) begin go(1, 1, NX, 8'h00, 1, 0); tick(); end
    chk("rs_tmo", {7'd0, tmo}, 8'd0);
    go(1, 1, NX, 8'h00, 1, 1); tick();
    chk("rs_adv_upc", upc, 8'h01);

`ifdef USEQ_STACK_EN
    // Return stack: CALL/RET pair, then nesting to overflow.
    go(0, 1, NX, 8'h00, 0, 0); tick();
    for (int k = 0; k < 5; k++) begin go(1, 1, NX, 8'h00, 0, 0); tick(); end
    chk("st_pre_upc", upc, 8'h05);
    go(1, 1, CL, 8'h20, 0, 0); tick();
    chk("st_call_upc", upc, 8'h20);
    chk("st_call_depth", {5'd0, depth}, 8'd1);
    go(1, 1, RT, 8'h00, 0, 0); tick();
    chk("st_ret_upc", upc, 8'h06);
    chk("st_ret_depth", {5'd0, depth}, 8'd0);
    for (int k = 0; k < 4; k++) begin go(1, 1, CL, 8'h30 + 8'(k), 0, 0); tick(); end
    chk("st_n4_upc", upc, 8'h33);
    chk("st_n4_depth", {5'd0, depth}, 8'd4);
    go(1, 1, RT, 8'h00, 0, 0); tick();
    chk("st_lifo_upc", upc, 8'h33);
    chk("st_lifo_depth", {5'd0, depth}, 8'd3);
    go(1, 1, CL, 8'h40, 0, 0); tick();
    chk("st_refill_upc", upc, 8'h40);
    go(1, 1, CL, 8'h41, 0, 0); tick();
    chk("st_ovf_upc", upc, 8'h40);
    chk("st_ovf_err", {7'd0, stk_err}, 8'd1);
    chk("st_ovf_halted", {7'd0, halted}, 8'd1);
    chk("st_ovf_depth", {5'd0, depth}, 8'd4);
    go(0, 1, NX, 8'h00, 0, 0); tick();
    chk("st_rst_err", {7'd0, stk_err}, 8'd0);
    go(1, 1, RT, 8'h00, 0, 0); tick();
    chk("st_unf_upc", upc, 8'h00);
    chk("st_unf_err", {7'd0, stk_err}, 8'd1);
    chk("st_unf_halted", {7'd0, halted}, 8'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Backstop against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
